// File: rtl/tag_rx_symb_accum.sv
// Coherent I/Q accumulate-and-dump started by a sync strobe; each symbol's
// sums are queued in a small FIFO that feeds an AXI-stream master.
module tag_rx_symb_accum #(
    parameter int DATA_WIDTH  = 16,
    parameter int NSIG        = 262144,
    parameter int NSYMB       = 1,
    parameter int NSYMB_WIDTH = 16,
    parameter int ACC_WIDTH   = 34,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run_rx,
    input  logic                         sym_start,
    input  logic                         rx_valid,
    input  logic signed [DATA_WIDTH-1:0] irx_bb,
    input  logic signed [DATA_WIDTH-1:0] qrx_bb,
    output logic [2*ACC_WIDTH-1:0]       m_tdata,
    output logic [NSYMB_WIDTH-1:0]       m_tuser,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         overflow,
    output logic [1:0]                   acc_state,
    output logic [15:0]                  sync_count
);

    localparam int CNT_W = $clog2(NSIG);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int EXT_W = ACC_WIDTH - DATA_WIDTH;
    localparam int ENT_W = 2*ACC_WIDTH + NSYMB_WIDTH + 1;

    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(NSIG - 1);
    localparam logic [NSYMB_WIDTH-1:0] IDX_LAST = NSYMB_WIDTH'(NSYMB - 1);
    localparam logic [PTR_W:0]         PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]         PTR_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        ACCUM     = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_WIDTH-1:0] acc_q_q, acc_q_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NSYMB_WIDTH-1:0]      idx_q, idx_d;
    logic [15:0]                 sync_q, sync_d;
    logic                        ovf_q;

    logic signed [ACC_WIDTH-1:0] sum_i, sum_q;
    logic                        idx_last;
    logic                        push;

    assign sum_i    = acc_i_q + {{EXT_W{irx_bb[DATA_WIDTH-1]}}, irx_bb};
    assign sum_q    = acc_q_q + {{EXT_W{qrx_bb[DATA_WIDTH-1]}}, qrx_bb};
    assign idx_last = (idx_q == IDX_LAST);

    always_comb begin
        state_d = state_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sync_d  = sync_q;
        push    = 1'b0;
        if (!run_rx) begin
            state_d = IDLE;
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_SYNC;
                WAIT_SYNC: begin
                    if (sym_start) begin
                        state_d = ACCUM;
                        acc_i_d = '0;
                        acc_q_d = '0;
                        cnt_d   = '0;
                        idx_d   = '0;
                        sync_d  = sync_q + 16'd1;
                    end
                end
                ACCUM: begin
                    if (rx_valid) begin
                        if (cnt_q == CNT_LAST) begin
                            push    = 1'b1;
                            acc_i_d = '0;
                            acc_q_d = '0;
                            cnt_d   = '0;
                            if (idx_last) begin
                                idx_d   = '0;
                                state_d = WAIT_SYNC;
                            end else begin
                                idx_d = idx_q + NSYMB_WIDTH'(1);
                            end
                        end else begin
                            acc_i_d = sum_i;
                            acc_q_d = sum_q;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                    // Resync lands after any completed symbol has been pushed.
                    if (sym_start) begin
                        state_d = ACCUM;
                        acc_i_d = '0;
                        acc_q_d = '0;
                        cnt_d   = '0;
                        idx_d   = '0;
                        sync_d  = sync_q + 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_q, rd_q, fill;
    logic [ENT_W-1:0] push_data, head;
    logic             full, pop, wr_en, drop;

    assign push_data = {sum_i, sum_q, idx_q, idx_last};
    assign fill      = wr_q - rd_q;
    assign full      = (fill == PTR_FULL);
    assign m_tvalid  = (fill != '0);
    assign pop       = m_tvalid && m_tready;
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign head      = mem_q[rd_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_i_q <= '0;
            acc_q_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            sync_q  <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sync_q  <= sync_d;
            if (drop)  ovf_q <= 1'b1;
            if (wr_en) wr_q  <= wr_q + PTR_ONE;
            if (pop)   rd_q  <= rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[PTR_W-1:0]] <= push_data;
    end

    // Beat fields read as zero while the FIFO is empty.
    assign m_tdata    = m_tvalid ? head[ENT_W-1 -: 2*ACC_WIDTH] : '0;
    assign m_tuser    = m_tvalid ? head[NSYMB_WIDTH:1] : '0;
    assign m_tlast    = m_tvalid && head[0];
    assign overflow   = ovf_q;
    assign acc_state  = state_q;
    assign sync_count = sync_q;

endmodule

// File: tb/tb_tag_rx_symb_accum.sv
// Directed bench for tag_rx_symb_accum: a sample-list model predicts every
// beat and status output, plus hand-computed literal beats per scenario.
module tb_tag_rx_symb_accum;

    localparam int NSIG  = 8;
    localparam int NSYMB = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 19;

    logic               clk;
    logic               reset;
    logic               run_rx;
    logic               sym_start;
    logic               rx_valid;
    logic signed [15:0] irx_bb;
    logic signed [15:0] qrx_bb;
    logic [2*AW-1:0]    m_tdata;
    logic [15:0]        m_tuser;
    logic               m_tlast;
    logic               m_tvalid;
    logic               m_tready;
    logic               overflow;
    logic [1:0]         acc_state;
    logic [15:0]        sync_count;

    tag_rx_symb_accum #(
        .DATA_WIDTH (16),
        .NSIG       (NSIG),
        .NSYMB      (NSYMB),
        .NSYMB_WIDTH(16),
        .ACC_WIDTH  (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run_rx    (run_rx),
        .sym_start (sym_start),
        .rx_valid  (rx_valid),
        .irx_bb    (irx_bb),
        .qrx_bb    (qrx_bb),
        .m_tdata   (m_tdata),
        .m_tuser   (m_tuser),
        .m_tlast   (m_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .overflow  (overflow),
        .acc_state (acc_state),
        .sync_count(sync_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase (0 idle, 1 waiting for sync, 2 integrating), the list of
    // samples in the open symbol, and the expected beat queue.
    int              m_phase;
    int              m_idx;
    int              m_sync;
    bit              m_ovf;
    longint          cur_i[$];
    longint          cur_q[$];
    logic [2*AW-1:0] e_d[$];
    int              e_u[$];
    bit              e_l[$];

    bit              mp_pop, mp_have, mp_last;
    int              mp_fill, mp_u;
    longint          si, sq;
    logic [AW-1:0]   ti, tq;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_idx   = 0;
            m_sync  = 0;
            m_ovf   = 1'b0;
            cur_i.delete();
            cur_q.delete();
            e_d.delete();
            e_u.delete();
            e_l.delete();
        end else begin
            mp_pop  = (e_d.size() != 0) && m_tready;
            mp_have = 1'b0;
            if (!run_rx) begin
                m_phase = 0;
                m_idx   = 0;
                cur_i.delete();
                cur_q.delete();
            end else if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (sym_start) begin
                    m_phase = 2;
                    m_idx   = 0;
                    m_sync  = (m_sync + 1) % 65536;
                    cur_i.delete();
                    cur_q.delete();
                end
            end else begin
                if (rx_valid) begin
                    cur_i.push_back(longint'(irx_bb));
                    cur_q.push_back(longint'(qrx_bb));
                    if (cur_i.size() == NSIG) begin
                        si = 0;
                        sq = 0;
                        foreach (cur_i[k]) si += cur_i[k];
                        foreach (cur_q[k]) sq += cur_q[k];
                        ti      = si[AW-1:0];
                        tq      = sq[AW-1:0];
                        mp_have = 1'b1;
                        mp_u    = m_idx;
                        mp_last = (m_idx == NSYMB - 1);
                        cur_i.delete();
                        cur_q.delete();
                        if (mp_last) begin
                            m_idx   = 0;
                            m_phase = 1;
                        end else begin
                            m_idx++;
                        end
                    end
                end
                if (sym_start) begin
                    m_phase = 2;
                    m_idx   = 0;
                    m_sync  = (m_sync + 1) % 65536;
                    cur_i.delete();
                    cur_q.delete();
                end
            end
            mp_fill = e_d.size();
            if (mp_pop) begin
                void'(e_d.pop_front());
                void'(e_u.pop_front());
                void'(e_l.pop_front());
            end
            if (mp_have) begin
                if (mp_fill < DEPTH || mp_pop) begin
                    e_d.push_back({ti, tq});
                    e_u.push_back(mp_u);
                    e_l.push_back(mp_last);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tvalid", 64'(m_tvalid), 64'(e_d.size() != 0));
            if (e_d.size() != 0) begin
                chk("tdata", 64'(m_tdata), 64'(e_d[0]));
                chk("tuser", 64'(m_tuser), 64'(e_u[0]));
                chk("tlast", 64'(m_tlast), 64'(e_l[0]));
            end
            chk("acc_state", 64'(acc_state), 64'(m_phase));
            chk("sync_count", 64'(sync_count), 64'(m_sync));
            chk("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    logic [2*AW-1:0] got_d[$];
    logic [15:0]     got_u[$];
    logic            got_l[$];

    always @(posedge clk) begin
        if (!reset && m_tvalid && m_tready) begin
            got_d.push_back(m_tdata);
            got_u.push_back(m_tuser);
            got_l.push_back(m_tlast);
        end
    end

    function automatic logic [2*AW-1:0] gd(input int k);
        if (k < got_d.size()) return got_d[k];
        return 'x;
    endfunction

    function automatic logic [15:0] gu(input int k);
        if (k < got_u.size()) return got_u[k];
        return 'x;
    endfunction

    function automatic logic gl(input int k);
        if (k < got_l.size()) return got_l[k];
        return 1'bx;
    endfunction

    task automatic clr_got();
        got_d.delete();
        got_u.delete();
        got_l.delete();
    endtask

    task automatic step(input bit v, input int i, input int q, input bit ss);
        rx_valid  = v;
        irx_bb    = i[15:0];
        qrx_bb    = q[15:0];
        sym_start = ss;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        run_rx = 1'b0;
        idle(2);
        reset  = 1'b0;
    endtask

    task automatic do_start();
        do_reset();
        run_rx = 1'b1;
        idle(1);
    endtask

    initial begin
        reset     = 1'b1;
        run_rx    = 1'b0;
        sym_start = 1'b0;
        rx_valid  = 1'b0;
        irx_bb    = '0;
        qrx_bb    = '0;
        m_tready  = 1'b1;

        // reset state
        do_reset();
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_tdata), 64'd0);
        chk("rst_tuser", 64'(m_tuser), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_state", 64'(acc_state), 64'd0);
        chk("rst_sync", 64'(sync_count), 64'd0);
        chk_en = 1'b1;

        // 1: two symbols of I=1, Q=-2
        clr_got();
        run_rx = 1'b1;
        idle(1);
        step(1'b0, 0, 0, 1'b1);
        for (int s = 0; s < 16; s++) step(1'b1, 1, -2, 1'b0);
        idle(3);
        chk("t1_beats", 64'(got_d.size()), 64'd2);
        chk("t1_d0", 64'(gd(0)), 64'({19'd8, 19'h7FFF0}));
        chk("t1_u0", 64'(gu(0)), 64'd0);
        chk("t1_l0", 64'(gl(0)), 64'd0);
        chk("t1_d1", 64'(gd(1)), 64'({19'd8, 19'h7FFF0}));
        chk("t1_u1", 64'(gu(1)), 64'd1);
        chk("t1_l1", 64'(gl(1)), 64'd1);
        chk("t1_state", 64'(acc_state), 64'd1);
        chk("t1_sync", 64'(sync_count), 64'd1);

        // 2: full-scale samples, valid every other cycle
        clr_got();
        step(1'b0, 0, 0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step(k % 2 == 0, 32767, -32768, 1'b0);
            if (k == 13) chk("t2_pre_tvalid", 64'(m_tvalid), 64'd0);
            if (k == 14) begin
                chk("t2_tvalid", 64'(m_tvalid), 64'd1);
                chk("t2_tdata", 64'(m_tdata), 64'({19'h3FFF8, 19'h40000}));
                chk("t2_tuser", 64'(m_tuser), 64'd0);
            end
        end
        idle(2);
        chk("t2_beats", 64'(got_d.size()), 64'd1);
        chk("t2_sync", 64'(sync_count), 64'd2);
        chk("t2_state", 64'(acc_state), 64'd2);

        // 3: resync after 5 samples discards the partial symbol
        do_start();
        clr_got();
        step(1'b0, 0, 0, 1'b1);
        for (int s = 0; s < 5; s++) step(1'b1, 100, 1, 1'b0);
        step(1'b1, 999, 999, 1'b1);
        for (int k = 1; k <= 8; k++) step(1'b1, k, -k, 1'b0);
        idle(3);
        chk("t3_beats", 64'(got_d.size()), 64'd1);
        chk("t3_d0", 64'(gd(0)), 64'({19'd36, 19'h7FFDC}));
        chk("t3_u0", 64'(gu(0)), 64'd0);
        chk("t3_sync", 64'(sync_count), 64'd2);

        // 4: stalled sink, three groups overfill the FIFO
        do_start();
        clr_got();
        m_tready = 1'b0;
        for (int g = 1; g <= 3; g++) begin
            step(1'b0, 0, 0, 1'b1);
            for (int s = 0; s < 16; s++) begin
                step(1'b1, g, -g, 1'b0);
                if (g == 3 && s == 7) chk("t4_ovf_set", 64'(overflow), 64'd1);
            end
            if (g == 2) chk("t4_ovf_clr", 64'(overflow), 64'd0);
        end
        m_tready = 1'b1;
        idle(6);
        chk("t4_beats", 64'(got_d.size()), 64'd4);
        chk("t4_u0", 64'(gu(0)), 64'd0);
        chk("t4_u1", 64'(gu(1)), 64'd1);
        chk("t4_u2", 64'(gu(2)), 64'd0);
        chk("t4_u3", 64'(gu(3)), 64'd1);
        chk("t4_d0", 64'(gd(0)), 64'({19'd8, 19'h7FFF8}));
        chk("t4_d2", 64'(gd(2)), 64'({19'd16, 19'h7FFF0}));
        chk("t4_ovf_sticky", 64'(overflow), 64'd1);

        // 5: run_rx dropped mid-symbol with two beats queued
        do_start();
        clr_got();
        m_tready = 1'b0;
        step(1'b0, 0, 0, 1'b1);
        for (int s = 0; s < 16; s++) step(1'b1, 3, 4, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        for (int s = 0; s < 3; s++) step(1'b1, 5, 5, 1'b0);
        run_rx = 1'b0;
        step(1'b1, 7, 7, 1'b0);
        chk("t5_idle", 64'(acc_state), 64'd0);
        m_tready = 1'b1;
        for (int k = 0; k < 10; k++) step(1'b1, 9, 9, k == 3);
        chk("t5_beats", 64'(got_d.size()), 64'd2);
        chk("t5_d0", 64'(gd(0)), 64'({19'd24, 19'd32}));
        chk("t5_u1", 64'(gu(1)), 64'd1);
        run_rx = 1'b1;
        for (int k = 0; k < 12; k++) step(1'b1, 2, 2, 1'b0);
        chk("t5_nopush", 64'(m_tvalid), 64'd0);
        chk("t5_wait", 64'(acc_state), 64'd1);
        step(1'b0, 0, 0, 1'b1);
        for (int s = 0; s < 8; s++) step(1'b1, 2, 2, 1'b0);
        idle(2);
        chk("t5_beats2", 64'(got_d.size()), 64'd3);
        chk("t5_d2", 64'(gd(2)), 64'({19'd16, 19'd16}));

        // 6: strobe coincident with the completing sample
        do_start();
        clr_got();
        step(1'b0, 0, 0, 1'b1);
        for (int s = 0; s < 7; s++) step(1'b1, 5, -5, 1'b0);
        step(1'b1, 5, -5, 1'b1);
        for (int s = 0; s < 8; s++) step(1'b1, 1, 1, 1'b0);
        idle(3);
        chk("t6_beats", 64'(got_d.size()), 64'd2);
        chk("t6_d0", 64'(gd(0)), 64'({19'd40, 19'h7FFD8}));
        chk("t6_u0", 64'(gu(0)), 64'd0);
        chk("t6_d1", 64'(gd(1)), 64'({19'd8, 19'd8}));
        chk("t6_u1", 64'(gu(1)), 64'd0);
        chk("t6_l1", 64'(gl(1)), 64'd0);
        chk("t6_sync", 64'(sync_count), 64'd2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
